kbd_scan_capture: RTL and testbench

KBD_SCAN_CAPTURE -- requirements
Module: kbd_scan_capture

---
 rtl/kbd_scan_capture.sv | 228 ++++++++++++++++++++++
 tb/tb_kbd_scan_capture.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kbd_scan_capture.sv
// PS/2 keyboard scan-code capture.
// Synchronizes the PS/2 clock/data pins, deserializes 11-bit frames
// (start, 8 data LSB first, odd parity, stop), aborts stalled frames,
// and tracks make/break sequences for a single displayed key with a
// two-digit BCD press counter.
module kbd_scan_capture #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] key_code,
  output logic       key_held,
  output logic [7:0] cnt_bcd,
  output logic       code_valid,
  output logic       frame_err
);

  localparam int            TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]    LAST_BIT = 4'd10;
  localparam logic [7:0]    CODE_EXT = 8'hE0;
  localparam logic [7:0]    CODE_BRK = 8'hF0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HELD  = 2'd1,
    ST_BREAK = 2'd2
  } state_t;

  // ---------------------------------------------------------------
  // Pin synchronizers and falling-edge detect
  // ---------------------------------------------------------------
  logic [SYNC_STAGES-1:0] clk_sync_q;
  logic [SYNC_STAGES-1:0] data_sync_q;
  logic                   clk_prev_q;
  logic                   ps2_clk_s;
  logic                   ps2_data_s;
  logic                   fall;

  assign ps2_clk_s  = clk_sync_q[SYNC_STAGES-1];
  assign ps2_data_s = data_sync_q[SYNC_STAGES-1];
  assign fall       = clk_prev_q & ~ps2_clk_s;

  // Shift pins through the synchronizer; reset to the idle-high level so
  // leaving reset can never look like a falling edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync_q  <= '1;
      data_sync_q <= '1;
      clk_prev_q  <= 1'b1;
    end else begin
      clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
      data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data};
      clk_prev_q  <= ps2_clk_s;
    end
  end

  // ---------------------------------------------------------------
  // Frame receiver with stall timeout
  // ---------------------------------------------------------------
  logic [9:0]    shift_q,    shift_d;
  logic [3:0]    bit_cnt_q,  bit_cnt_d;
  logic [TW-1:0] to_cnt_q,   to_cnt_d;
  logic          byte_stb_q, byte_stb_d;
  logic [7:0]    byte_q,     byte_d;
  logic          frame_err_q, frame_err_d;
  logic [10:0]   frame_w;
  logic          frame_ok;

  // The 11th bit is used live from the synchronizer, so only 10 bits are
  // stored. frame_w[0] is the start bit, frame_w[10] the stop bit.
  assign frame_w  = {ps2_data_s, shift_q};
  assign frame_ok = ~frame_w[0] & frame_w[10] & (^frame_w[9:1]);

  // Next-state logic for bit collection, frame check and timeout abort.
  always_comb begin
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    to_cnt_d    = to_cnt_q;
    byte_stb_d  = 1'b0;
    byte_d      = byte_q;
    frame_err_d = 1'b0;
    if (fall) begin
      // Any edge restarts the stall window, including the closing edge.
      to_cnt_d = '0;
      if (bit_cnt_q == LAST_BIT) begin
        bit_cnt_d = 4'd0;
        if (frame_ok) begin
          byte_stb_d = 1'b1;
          byte_d     = frame_w[8:1];
        end else begin
          frame_err_d = 1'b1;
        end
      end else begin
        shift_d   = frame_w[10:1];
        bit_cnt_d = bit_cnt_q + 4'd1;
      end
    end else if (bit_cnt_q != 4'd0) begin
      // Only a partially received frame can stall; idle time is free.
      if (to_cnt_q == TO_LAST) begin
        bit_cnt_d   = 4'd0;
        to_cnt_d    = '0;
        frame_err_d = 1'b1;
      end else begin
        to_cnt_d = to_cnt_q + TW'(1);
      end
    end
  end

  // Receiver state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q     <= '0;
      bit_cnt_q   <= 4'd0;
      to_cnt_q    <= '0;
      byte_stb_q  <= 1'b0;
      byte_q      <= 8'h00;
      frame_err_q <= 1'b0;
    end else begin
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      to_cnt_q    <= to_cnt_d;
      byte_stb_q  <= byte_stb_d;
      byte_q      <= byte_d;
      frame_err_q <= frame_err_d;
    end
  end

  // ---------------------------------------------------------------
  // Key tracking FSM and BCD press counter
  // ---------------------------------------------------------------
  state_t     state_q,      state_d;
  logic [7:0] key_code_q,   key_code_d;
  logic       key_held_q,   key_held_d;
  logic [7:0] cnt_q,        cnt_d;
  logic       code_valid_q, code_valid_d;
  logic [7:0] cnt_inc;
  logic       accept;

  // Two-digit BCD increment; ones roll into tens, 99 rolls to 00.
  always_comb begin
    cnt_inc = cnt_q;
    if (cnt_q[3:0] == 4'd9) begin
      cnt_inc[3:0] = 4'd0;
      cnt_inc[7:4] = (cnt_q[7:4] == 4'd9) ? 4'd0 : cnt_q[7:4] + 4'd1;
    end else begin
      cnt_inc[3:0] = cnt_q[3:0] + 4'd1;
    end
  end

  // Interpret each received byte against the make/break protocol.
  always_comb begin
    state_d      = state_q;
    key_code_d   = key_code_q;
    key_held_d   = key_held_q;
    cnt_d        = cnt_q;
    code_valid_d = 1'b0;
    accept       = 1'b0;
    // Extended-code prefix carries no information for a single-key display.
    if (byte_stb_q && (byte_q != CODE_EXT)) begin
      case (state_q)
        ST_IDLE: begin
          if (byte_q == CODE_BRK) begin
            state_d = ST_BREAK;
          end else begin
            accept  = 1'b1;
            state_d = ST_HELD;
          end
        end
        ST_HELD: begin
          if (byte_q == key_code_q) begin
            // Typematic repeat of the held key: nothing to report.
            state_d = ST_HELD;
          end else if (byte_q == CODE_BRK) begin
            state_d = ST_BREAK;
          end else begin
            accept = 1'b1;
          end
        end
        ST_BREAK: begin
          if ((byte_q == key_code_q) && key_held_q) begin
            key_held_d = 1'b0;
            state_d    = ST_IDLE;
          end else begin
            // Release of some other key: fall back to whatever we were showing.
            state_d = key_held_q ? ST_HELD : ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
    if (accept) begin
      key_code_d   = byte_q;
      key_held_d   = 1'b1;
      cnt_d        = cnt_inc;
      code_valid_d = 1'b1;
    end
  end

  // Key FSM and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      key_code_q   <= 8'h00;
      key_held_q   <= 1'b0;
      cnt_q        <= 8'h00;
      code_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      key_code_q   <= key_code_d;
      key_held_q   <= key_held_d;
      cnt_q        <= cnt_d;
      code_valid_q <= code_valid_d;
    end
  end

  assign key_code   = key_code_q;
  assign key_held   = key_held_q;
  assign cnt_bcd    = cnt_q;
  assign code_valid = code_valid_q;
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_kbd_scan_capture.sv
// Bench for kbd_scan_capture: drives PS/2 frames, predicts outputs with a
// byte-level protocol model and fixed pipeline latencies, checks every cycle.
module tb_kbd_scan_capture;

  localparam int S       = 2;
  localparam int T       = 40;
  localparam int LAT_ERR = S + 1;  // frame error visible after the edge
  localparam int LAT_KEY = S + 2;  // key outputs one cycle later

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] key_code;
  logic       key_held;
  logic [7:0] cnt_bcd;
  logic       code_valid;
  logic       frame_err;

  kbd_scan_capture #(.SYNC_STAGES(S), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .key_code(key_code), .key_held(key_held), .cnt_bcd(cnt_bcd),
    .code_valid(code_valid), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Scheduled expectation changes: kind 0 reset, 1 key update, 2 frame error.
  typedef struct {
    int         at;
    int         kind;
    logic [7:0] kc;
    bit         held;
    logic [7:0] cnt;
    bit         cv;
  } ev_t;
  ev_t evq[$];

  // Protocol-level model state.
  int         m_state = 0;  // 0 idle, 1 held, 2 break
  logic [7:0] m_kc = 8'h00;
  bit         m_held = 1'b0;
  int         m_cnt = 0;
  bit         mbits[$];
  int         last_fall = 0;

  // Currently expected DUT outputs.
  logic [7:0] e_kc = 8'h00;
  bit         e_held = 1'b0;
  logic [7:0] e_cnt = 8'h00;
  bit         e_cv = 1'b0;
  bit         e_fe = 1'b0;
  bit         chk_en = 1'b0;

  int cv_seen = 0;
  int fe_seen = 0;
  int last_cv_cyc = -1;

  function automatic logic [7:0] to_bcd(input int n);
    logic [7:0] r;
    r[7:4] = 4'(n / 10);
    r[3:0] = 4'(n % 10);
    return r;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic push_ev(input int at, input int kind, input bit cv);
    ev_t e;
    e.at   = at;
    e.kind = kind;
    e.kc   = m_kc;
    e.held = m_held;
    e.cnt  = to_bcd(m_cnt);
    e.cv   = cv;
    evq.push_back(e);
  endtask

  // Make/break protocol applied to one accepted byte.
  task automatic model_byte(input logic [7:0] b);
    bit acc;
    acc = 1'b0;
    if (b != 8'hE0) begin
      case (m_state)
        0: if (b == 8'hF0) m_state = 2; else acc = 1'b1;
        1: if (b != m_kc) begin
             if (b == 8'hF0) m_state = 2; else acc = 1'b1;
           end
        default: begin
          if (b == m_kc && m_held) begin
            m_held  = 1'b0;
            m_state = 0;
          end else begin
            m_state = m_held ? 1 : 0;
          end
        end
      endcase
      if (acc) begin
        m_kc    = b;
        m_held  = 1'b1;
        m_cnt   = (m_cnt + 1) % 100;
        m_state = 1;
      end
      push_ev(cyc + LAT_KEY, 1, acc);
    end
  endtask

  // Called at the moment the bench drives ps2_clk low.
  task automatic model_fall(input bit b);
    logic [7:0] d;
    bit         ok;
    last_fall = cyc;
    mbits.push_back(b);
    if (mbits.size() == 11) begin
      for (int i = 0; i < 8; i++) d[i] = mbits[i + 1];
      ok = (mbits[0] == 1'b0) && (mbits[10] == 1'b1) && ((^d ^ mbits[9]) == 1'b1);
      mbits.delete();
      if (ok) model_byte(d);
      else    push_ev(cyc + LAT_ERR, 2, 1'b0);
    end
  endtask

  // Per-cycle: timeout prediction, apply due expectations, compare.
  always @(negedge clk) begin
    if (mbits.size() > 0 && (cyc - last_fall) == T) begin
      push_ev(cyc + LAT_ERR, 2, 1'b0);
      mbits.delete();
    end
    e_cv = 1'b0;
    e_fe = 1'b0;
    for (int i = evq.size() - 1; i >= 0; i--) begin
      if (evq[i].at == cyc) begin
        case (evq[i].kind)
          0: begin
            e_kc = 8'h00; e_held = 1'b0; e_cnt = 8'h00; chk_en = 1'b1;
          end
          1: begin
            e_kc = evq[i].kc; e_held = evq[i].held; e_cnt = evq[i].cnt; e_cv = evq[i].cv;
          end
          default: e_fe = 1'b1;
        endcase
        evq.delete(i);
      end
    end
    if (code_valid === 1'b1) begin
      cv_seen++;
      last_cv_cyc = cyc;
    end
    if (frame_err === 1'b1) fe_seen++;
    if (chk_en) begin
      chk("key_code", key_code, e_kc);
      chk("key_held", {7'b0, key_held}, {7'b0, e_held});
      chk("cnt_bcd", cnt_bcd, e_cnt);
      chk("code_valid", {7'b0, code_valid}, {7'b0, e_cv});
      chk("frame_err", {7'b0, frame_err}, {7'b0, e_fe});
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    m_state = 0; m_kc = 8'h00; m_held = 1'b0; m_cnt = 0;
    mbits.delete();
    evq.delete();
    push_ev(cyc + 1, 0, 1'b0);
    tick(1);
    rst = 1'b0;
  endtask

  task automatic send_bit(input bit b);
    int h;
    h = $urandom_range(2, 5);
    ps2_data = b;
    tick(h);
    ps2_clk = 1'b0;
    model_fall(b);
    tick(h);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input bit bad_par,
                            input bit bad_start, input bit bad_stop);
    bit p;
    p = ~(^d) ^ bad_par;
    send_bit(bad_start);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(p);
    send_bit(~bad_stop);
    ps2_data = 1'b1;
    tick($urandom_range(3, 12));
  endtask

  initial begin
    int cv0, fe0, sc, r, sel, k;
    logic [7:0] b;

    do_reset();
    tick(3);
    chk("reset_key_code", key_code, 8'h00);
    chk("reset_key_held", {7'b0, key_held}, 8'h00);
    chk("reset_cnt", cnt_bcd, 8'h00);

    // Single valid make code and its exact code_valid timing.
    cv0 = cv_seen;
    send_frame(8'h1C, 0, 0, 0);
    sc = last_fall;
    tick(10);
    chk("make_key_code", key_code, 8'h1C);
    chk("make_key_held", {7'b0, key_held}, 8'h01);
    chk("make_cnt", cnt_bcd, 8'h01);
    chk_int("make_cv_pulses", cv_seen - cv0, 1);
    chk_int("make_cv_cycle", last_cv_cyc, sc + 4);

    // Repeat, break, release sequence from reset.
    do_reset();
    tick(2);
    cv0 = cv_seen;
    send_frame(8'h1C, 0, 0, 0);
    send_frame(8'h1C, 0, 0, 0);
    send_frame(8'h1C, 0, 0, 0);
    send_frame(8'hF0, 0, 0, 0);
    send_frame(8'h1C, 0, 0, 0);
    tick(10);
    chk_int("seq_cv_pulses", cv_seen - cv0, 1);
    chk("seq_cnt", cnt_bcd, 8'h01);
    chk("seq_key_held", {7'b0, key_held}, 8'h00);

    // Bad parity is rejected with a single error pulse.
    fe0 = fe_seen;
    send_frame(8'h1C, 1, 0, 0);
    tick(10);
    chk_int("parity_fe_pulses", fe_seen - fe0, 1);
    chk("parity_cnt", cnt_bcd, 8'h01);
    chk("parity_key_code", key_code, 8'h1C);

    // Stalled partial frame, then a clean frame.
    fe0 = fe_seen;
    for (int i = 0; i < 5; i++) send_bit($urandom_range(0, 1));
    tick(T + 10);
    chk_int("timeout_fe_pulses", fe_seen - fe0, 1);
    send_frame(8'h2B, 0, 0, 0);
    tick(10);
    chk("after_timeout_key_code", key_code, 8'h2B);
    chk("after_timeout_cnt", cnt_bcd, 8'h02);

    // Reset in the middle of a frame.
    cv0 = cv_seen;
    fe0 = fe_seen;
    for (int i = 0; i < 6; i++) send_bit($urandom_range(0, 1));
    tick(4);
    do_reset();
    tick(2);
    send_frame(8'h1C, 0, 0, 0);
    tick(10);
    chk_int("midreset_fe_pulses", fe_seen - fe0, 0);
    chk_int("midreset_cv_pulses", cv_seen - cv0, 1);
    chk("midreset_cnt", cnt_bcd, 8'h01);

    // 100 make/break pairs: BCD carry and wrap.
    do_reset();
    tick(2);
    for (int i = 1; i <= 100; i++) begin
      send_frame(8'h23, 0, 0, 0);
      send_frame(8'hF0, 0, 0, 0);
      send_frame(8'h23, 0, 0, 0);
      tick(8);
      if (i == 9)   chk("bcd_9", cnt_bcd, 8'h09);
      if (i == 10)  chk("bcd_10", cnt_bcd, 8'h10);
      if (i == 99)  chk("bcd_99", cnt_bcd, 8'h99);
      if (i == 100) chk("bcd_100", cnt_bcd, 8'h00);
    end

    // Randomized mix of codes, corrupt frames and aborts.
    for (int n = 0; n < 80; n++) begin
      r   = $urandom_range(0, 19);
      sel = $urandom_range(0, 5);
      case (sel)
        0: b = 8'h1C;
        1: b = 8'h23;
        2: b = 8'h2B;
        3: b = 8'hF0;
        4: b = 8'hE0;
        default: b = 8'($urandom_range(0, 255));
      endcase
      case (r)
        0: send_frame(b, 1, 0, 0);
        1: send_frame(b, 0, 1, 0);
        2: send_frame(b, 0, 0, 1);
        3: begin
          k = $urandom_range(1, 10);
          for (int i = 0; i < k; i++) send_bit($urandom_range(0, 1));
          ps2_data = 1'b1;
          tick(T + 5);
        end
        default: send_frame(b, 0, 0, 0);
      endcase
    end
    tick(12);
    chk_int("events_drained", evq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
